// File: rtl/risc_pkg.sv
// -----------------------------------------------------------------------------
// risc_pkg
// Shared definitions for the fetch/decode boundary.
//   DEF_WORD_W / DEF_PC_W : default instruction word and program counter widths
//   OPC_HI / OPC_LO       : bit range of the opcode class field in a word
//   IMM_CLASS             : opcode class value that marks a two-word instruction
//   state_t               : assembly state (waiting for opcode / immediate)
// -----------------------------------------------------------------------------
package risc_pkg;

    localparam int DEF_WORD_W = 16;
    localparam int DEF_PC_W   = 32;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 13;

    localparam logic [OPC_HI-OPC_LO:0] IMM_CLASS = 3'b110;

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_t;

endpackage

// File: rtl/if_id_buffer_if.sv
// -----------------------------------------------------------------------------
// if_id_buffer_if
// Bundles the fetch-side and decode-side signals of the IF/ID buffer.
//   in_word/in_pc/in_valid : fetched word, its address and its qualifier
//   in_ready               : buffer takes the word this cycle
//   stall/flush            : decode back-pressure and hazard/branch discard
//   out_instr/out_pc       : assembled packet and PC of its opcode word
//   out_has_imm/out_valid  : immediate present / packet valid for decode
// master: the pipeline around the buffer.  slave: the buffer itself.
// -----------------------------------------------------------------------------
interface if_id_buffer_if
    import risc_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int PC_W   = DEF_PC_W
);

    logic [WORD_W-1:0]   in_word;
    logic [PC_W-1:0]     in_pc;
    logic                in_valid;
    logic                in_ready;
    logic                stall;
    logic                flush;
    logic [2*WORD_W-1:0] out_instr;
    logic [PC_W-1:0]     out_pc;
    logic                out_has_imm;
    logic                out_valid;

    modport master (
        output in_word, in_pc, in_valid, stall, flush,
        input  in_ready, out_instr, out_pc, out_has_imm, out_valid
    );

    modport slave (
        input  in_word, in_pc, in_valid, stall, flush,
        output in_ready, out_instr, out_pc, out_has_imm, out_valid
    );

endinterface

// File: rtl/if_id_buffer.sv
// -----------------------------------------------------------------------------
// if_id_buffer
// Pipeline register between fetch and decode.  Accepts 16-bit words with their
// PC and presents one 32-bit packet per complete instruction: one-word
// instructions carry a zero immediate, two-word instructions (opcode class
// IMM_CLASS) are joined with the word that follows them.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low; clears all state immediately
//   bus   : if_id_buffer_if.slave (fetch inputs, stall/flush, decode packet)
// -----------------------------------------------------------------------------
module if_id_buffer
    import risc_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int PC_W   = DEF_PC_W
) (
    input  logic          clk,
    input  logic          reset,
    if_id_buffer_if.slave bus
);

    state_t              r_state;
    logic [WORD_W-1:0]   r_holdHi;
    logic [PC_W-1:0]     r_holdPc;
    logic [2*WORD_W-1:0] r_outInstr;
    logic [PC_W-1:0]     r_outPc;
    logic                r_outHasImm;
    logic                r_outValid;

    logic                w_ready;
    logic                w_accept;
    logic                w_isTwoWord;

    // Ready depends only on stall/flush, so it stays meaningful during reset.
    assign w_ready     = !bus.stall && !bus.flush;
    assign w_accept    = bus.in_valid && w_ready;
    assign w_isTwoWord = (bus.in_word[OPC_HI:OPC_LO] == IMM_CLASS);

    assign bus.in_ready    = w_ready;
    assign bus.out_instr   = r_outInstr;
    assign bus.out_pc      = r_outPc;
    assign bus.out_has_imm = r_outHasImm;
    assign bus.out_valid   = r_outValid;

    // Flush outranks stall; a stall freezes everything including out_valid.
    // In S_IMM the accepted word is taken as the immediate without decoding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_OP;
            r_holdHi    <= '0;
            r_holdPc    <= '0;
            r_outInstr  <= '0;
            r_outPc     <= '0;
            r_outHasImm <= 1'b0;
            r_outValid  <= 1'b0;
        end else if (bus.flush) begin
            r_outValid <= 1'b0;
            r_state    <= S_OP;
        end else if (w_accept) begin
            if (r_state == S_IMM) begin
                r_outInstr  <= {r_holdHi, bus.in_word};
                r_outPc     <= r_holdPc;
                r_outHasImm <= 1'b1;
                r_outValid  <= 1'b1;
                r_state     <= S_OP;
            end else if (w_isTwoWord) begin
                r_holdHi   <= bus.in_word;
                r_holdPc   <= bus.in_pc;
                r_outValid <= 1'b0;
                r_state    <= S_IMM;
            end else begin
                r_outInstr  <= {bus.in_word, {WORD_W{1'b0}}};
                r_outPc     <= bus.in_pc;
                r_outHasImm <= 1'b0;
                r_outValid  <= 1'b1;
            end
        end else if (!bus.stall) begin
            r_outValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// -----------------------------------------------------------------------------
// tb_if_id_buffer
// Directed bench for if_id_buffer.  A packet-level reference model tracks the
// instruction being assembled from accepted words; a per-cycle monitor compares
// the DUT against it, and hand-computed expectations pin specific scenarios.
// -----------------------------------------------------------------------------
module tb_if_id_buffer;

    logic clk;
    logic reset;

    int total;
    int bad;

    if_id_buffer_if bus ();

    if_id_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what decode should currently see, built from the
    // accepted-word stream.  pending means an opcode is waiting for its
    // immediate word.
    logic        mValid;
    logic [31:0] mInstr;
    logic [31:0] mPc;
    logic        mHasImm;
    logic        mPending;
    logic [15:0] mHi;
    logic [31:0] mHiPc;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mValid   = 1'b0;
            mInstr   = 32'h0;
            mPc      = 32'h0;
            mHasImm  = 1'b0;
            mPending = 1'b0;
            mHi      = 16'h0;
            mHiPc    = 32'h0;
        end else if (bus.flush) begin
            mValid   = 1'b0;
            mPending = 1'b0;
        end else if (bus.stall) begin
            mValid = mValid;
        end else if (bus.in_valid) begin
            if (mPending) begin
                mInstr   = {mHi, bus.in_word};
                mPc      = mHiPc;
                mHasImm  = 1'b1;
                mValid   = 1'b1;
                mPending = 1'b0;
            end else if (bus.in_word[15:13] == 3'b110) begin
                mHi      = bus.in_word;
                mHiPc    = bus.in_pc;
                mPending = 1'b1;
                mValid   = 1'b0;
            end else begin
                mInstr  = {bus.in_word, 16'h0000};
                mPc     = bus.in_pc;
                mHasImm = 1'b0;
                mValid  = 1'b1;
            end
        end else begin
            mValid = 1'b0;
        end
    end

    task automatic checkValue(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle monitor against the reference model, away from the active edge.
    always @(negedge clk) begin
        checkValue("mon_in_ready", {63'b0, bus.in_ready}, {63'b0, (!bus.stall && !bus.flush)});
        checkValue("mon_out_valid", {63'b0, bus.out_valid}, {63'b0, mValid});
        checkValue("mon_out_instr", {32'b0, bus.out_instr}, {32'b0, mInstr});
        checkValue("mon_out_pc", {32'b0, bus.out_pc}, {32'b0, mPc});
        checkValue("mon_out_has_imm", {63'b0, bus.out_has_imm}, {63'b0, mHasImm});
    end

    task automatic applyStimulus(input logic valid, input logic [15:0] word,
                                 input logic [31:0] pc, input logic st,
                                 input logic fl);
        bus.in_valid = valid;
        bus.in_word  = word;
        bus.in_pc    = pc;
        bus.stall    = st;
        bus.flush    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic v,
                               input logic [31:0] instr, input logic [31:0] pc,
                               input logic hasImm);
        checkValue({name, "_valid"}, {63'b0, bus.out_valid}, {63'b0, v});
        checkValue({name, "_instr"}, {32'b0, bus.out_instr}, {32'b0, instr});
        checkValue({name, "_pc"}, {32'b0, bus.out_pc}, {32'b0, pc});
        checkValue({name, "_has_imm"}, {63'b0, bus.out_has_imm}, {63'b0, hasImm});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_word  = 16'h1234;
        bus.in_pc    = 32'h20;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;

        // Reset held low with a word offered: nothing gets through.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 32'h0, 32'h0, 1'b0);
        checkValue("reset_ready", {63'b0, bus.in_ready}, 64'd1);
        bus.stall = 1'b1;
        #1;
        checkValue("reset_ready_stall", {63'b0, bus.in_ready}, 64'd0);
        bus.stall = 1'b0;
        reset = 1'b1;

        // One-word instruction.
        applyStimulus(1'b1, 16'h1234, 32'h20, 1'b0, 1'b0);
        checkOutput("one_word", 1'b1, 32'h1234_0000, 32'h20, 1'b0);

        // Two-word instruction back to back.
        applyStimulus(1'b1, 16'hC801, 32'h21, 1'b0, 1'b0);
        checkValue("two_word_op_valid", {63'b0, bus.out_valid}, 64'd0);
        applyStimulus(1'b1, 16'h00FF, 32'h22, 1'b0, 1'b0);
        checkOutput("two_word", 1'b1, 32'hC801_00FF, 32'h21, 1'b1);
        idle(1);
        checkValue("two_word_one_cycle", {63'b0, bus.out_valid}, 64'd0);

        // Two-word instruction with a five-cycle fetch gap.
        applyStimulus(1'b1, 16'hC801, 32'h21, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 16'hAAAA, 32'h99, 1'b0, 1'b0);
            checkValue("gap_valid", {63'b0, bus.out_valid}, 64'd0);
        end
        applyStimulus(1'b1, 16'h00FF, 32'h22, 1'b0, 1'b0);
        checkOutput("gap_two_word", 1'b1, 32'hC801_00FF, 32'h21, 1'b1);

        // Stall freezes a valid packet; the offered word waits.
        applyStimulus(1'b1, 16'h1111, 32'h30, 1'b0, 1'b0);
        checkOutput("pre_stall", 1'b1, 32'h1111_0000, 32'h30, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h2222, 32'h31, 1'b1, 1'b0);
            checkOutput("stall_hold", 1'b1, 32'h1111_0000, 32'h30, 1'b0);
            checkValue("stall_ready", {63'b0, bus.in_ready}, 64'd0);
        end
        applyStimulus(1'b1, 16'h2222, 32'h31, 1'b0, 1'b0);
        checkOutput("post_stall", 1'b1, 32'h2222_0000, 32'h31, 1'b0);

        // Flush while an opcode waits: the immediate slot is abandoned.
        applyStimulus(1'b1, 16'hC801, 32'h40, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h5555, 32'h41, 1'b0, 1'b1);
        checkValue("flush_valid", {63'b0, bus.out_valid}, 64'd0);
        applyStimulus(1'b1, 16'h1234, 32'h42, 1'b0, 1'b0);
        checkOutput("after_flush", 1'b1, 32'h1234_0000, 32'h42, 1'b0);

        // Flush beats stall.
        applyStimulus(1'b1, 16'h3333, 32'h43, 1'b1, 1'b1);
        checkValue("flush_stall_valid", {63'b0, bus.out_valid}, 64'd0);

        // Class boundaries: 101 and 111 are one-word, an immediate with class
        // 110 is still just an immediate.
        applyStimulus(1'b1, 16'hA000, 32'h60, 1'b0, 1'b0);
        checkOutput("class_101", 1'b1, 32'hA000_0000, 32'h60, 1'b0);
        applyStimulus(1'b1, 16'hE000, 32'h61, 1'b0, 1'b0);
        checkOutput("class_111", 1'b1, 32'hE000_0000, 32'h61, 1'b0);
        applyStimulus(1'b1, 16'hC000, 32'h62, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hC802, 32'h70, 1'b0, 1'b0);
        checkOutput("imm_class_110", 1'b1, 32'hC000_C802, 32'h62, 1'b1);

        // Stall while waiting for the immediate keeps the partial opcode.
        applyStimulus(1'b1, 16'hD00D, 32'h80, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hBEEF, 32'h81, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'hBEEF, 32'h81, 1'b0, 1'b0);
        checkOutput("stall_in_imm", 1'b1, 32'hD00D_BEEF, 32'h80, 1'b1);

        // Back-to-back one-word stream.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'h0100 + 16'(i), 32'h90 + 32'(i), 1'b0, 1'b0);
            checkOutput("stream", 1'b1, {16'h0100 + 16'(i), 16'h0000}, 32'h90 + 32'(i), 1'b0);
        end

        // Asynchronous reset while an opcode waits.
        applyStimulus(1'b1, 16'hC801, 32'h50, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 32'h0, 32'h0, 1'b0);
        #3;
        reset = 1'b1;
        applyStimulus(1'b1, 16'h00FF, 32'h51, 1'b0, 1'b0);
        checkOutput("after_reset", 1'b1, 32'h00FF_0000, 32'h51, 1'b0);

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
